rio_frame_codec: RTL and testbench
==================================

Name: rio_frame_codec

Overview:
- Parametrised packet codec between the SPI slave frame buffer and the joint, vout, vin and digital I/O blocks.
- Generalises the fixed top-level packing into configurable channel counts.
- Adds registered, header-validated command latching and an atomic feedback snapshot.
- Adds a frame watchdog and an ESTOP state machine that drives the TX header and a global error line.

Parameters:
NUM_JOINTS, 5, joint channels (1..8)
NUM_VOUTS, 2, 32-bit setpoint channels (0..8)
NUM_VINS, 1, 32-bit process-variable channels (0..8)
NUM_DOUT, 4, digital outputs (1..8)
NUM_DIN, 5, digital inputs (1..8)
RX_HEADER, 32'h74697277, required header of a command frame
TIMEOUT_CYCLES, 100000, sysclk cycles without a valid frame before timeout (>=2)
BUFFER_SIZE, derived, max(32*(1+NUM_JOINTS+NUM_VOUTS)+16, 32*(1+NUM_JOINTS+NUM_VINS)+8)

Ports:
sysclk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_frame  in  BUFFER_SIZE  received SPI frame, MSB = first byte on wire
rx_strobe  in  1  one-cycle pulse: rx_frame complete and stable
estop_in  in  1  level ESTOP request
din  in  NUM_DIN  digital inputs
joint_feedback  in  32*NUM_JOINTS  joint positions, channel 0 in LSBs
process_variable  in  32*NUM_VINS  vin values
tx_frame  out  BUFFER_SIZE  frame to transmit, MSB first
joint_freq_cmd  out  32*NUM_JOINTS  joint frequency commands
joint_enable  out  NUM_JOINTS  per-joint enable, already gated by error
set_point  out  32*NUM_VOUTS  vout setpoints
dout  out  NUM_DOUT  digital outputs
error  out  1  timeout OR estop
frame_count  out  16  valid frames accepted, wraps

Behaviour:
- Reset values:
  - All command outputs, dout, joint_enable, frame_count = 0.
  - error = 1.
  - tx_frame = header "data" plus zeros.
  - State WAIT_FIRST.
- Wire format: each 32-bit word is sent little-endian (byte0 first in the frame).
- RX layout from MSB: header, joint cmd 0..J-1, setpoint 0..V-1, enable byte (bit i = joint i), dout byte (bit i = dout i), zero pad to BUFFER_SIZE.
- TX layout from MSB: header, feedback 0..J-1, pv 0..I-1, din byte (bit i = din i, unused bits 0), zero pad.
- Valid frame: rx_strobe=1 and decoded header == RX_HEADER.
- On a valid frame:
  - Command registers are loaded on the next edge (1-cycle latency).
  - frame_count increments, wrapping 0xFFFF->0.
  - Watchdog counter clears.
- On an invalid header: commands are held, the counter is not cleared, and frame_count is unchanged.
- Feedback snapshot: on any rx_strobe, joint_feedback, process_variable and din are captured together into tx_frame (1-cycle latency), so the next frame is coherent. The header field is updated every cycle from state.
- Watchdog counter:
  - Saturating; runs in every state except ESTOP.
  - Timeout is asserted when counter == TIMEOUT_CYCLES-1.
- States:
  - WAIT_FIRST: error=1. First valid frame -> RUN.
  - RUN: error=0. Watchdog expiry -> TIMEOUT.
  - TIMEOUT: error=1. Valid frame -> RUN, and that frame's commands are applied.
  - ESTOP: error=1, header "estp" (32'h65737470), else "data" (32'h64617461).
- estop_in=1 forces ESTOP from any state, with priority over a simultaneous valid frame.
- ESTOP is exited only when estop_in=0 and a valid frame arrives -> RUN.
- joint_enable = latched enable bits AND NOT error, combinational from registered state (same cycle as error).
- dout and set_point hold their last values under error; downstream blocks gate them using error.
- Reset mid-frame: all state is cleared immediately. A strobe coincident with reset deassertion is ignored.

Optional Feature:
RIO_FRAME_CHECKSUM_EN
- Defined:
  - The last RX byte is an XOR checksum of all preceding RX bytes; BUFFER_SIZE grows by 8.
  - Validity requires header match AND checksum match.
  - The TX last byte carries the XOR of preceding TX bytes.
  - Output csum_err (1 bit) pulses for one cycle on a header-good/checksum-bad frame.
- Undefined: no checksum byte, no csum_err port, layouts as above.

Test Plan:
- Reset, then one valid frame with joint0 cmd 0x00001234, enable 0x01, dout 0x05 -> next cycle joint_freq_cmd[31:0]=0x1234, joint_enable[0]=1, dout=0x5, error=0, frame_count=1.
- Frame with header 0xDEADBEEF -> outputs unchanged, frame_count unchanged, still WAIT_FIRST/error=1.
- Valid frame then no strobes for TIMEOUT_CYCLES -> error=1 and joint_enable=0 at cycle TIMEOUT_CYCLES; next valid frame -> error=0.
- estop_in=1 coincident with valid frame -> ESTOP, TX header 0x65737470. Release estop_in plus valid frame -> RUN, header 0x64617461.
- joint_feedback0=0x11223344 changed to 0x55667788 one cycle after rx_strobe -> tx_frame word carries bytes 44 33 22 11.
- 65536 valid frames -> frame_count wraps to 0. Checksum build: corrupt one byte -> csum_err pulse, commands held.

Source files
------------

// File: rtl/rio_frame_codec_if.sv
// rio_frame_codec_if: bundles the SPI frame buffers, the joint/vout/dout command
// outputs and the feedback inputs of rio_frame_codec into one port.
// Optional macro RIO_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte to both
// frames and the csum_err pulse.
interface rio_frame_codec_if #(
   parameter int NUM_JOINTS = 5,
   parameter int NUM_VOUTS  = 2,
   parameter int NUM_VINS   = 1,
   parameter int NUM_DOUT   = 4,
   parameter int NUM_DIN    = 5
);
   localparam int RX_BITS = 32*(1+NUM_JOINTS+NUM_VOUTS)+16;
   localparam int TX_BITS = 32*(1+NUM_JOINTS+NUM_VINS)+8;
`ifdef RIO_FRAME_CHECKSUM_EN
   localparam int BUFFER_SIZE = ((RX_BITS > TX_BITS) ? RX_BITS : TX_BITS) + 8;
`else
   localparam int BUFFER_SIZE = (RX_BITS > TX_BITS) ? RX_BITS : TX_BITS;
`endif
   // A build with zero vout or vin channels keeps one dummy word so the vectors stay legal.
   localparam int VOUT_W = (NUM_VOUTS > 0) ? 32*NUM_VOUTS : 32;
   localparam int VIN_W  = (NUM_VINS  > 0) ? 32*NUM_VINS  : 32;

   logic [BUFFER_SIZE-1:0]  rx_frame;
   logic                    rx_strobe;
   logic                    estop_in;
   logic [NUM_DIN-1:0]      din;
   logic [32*NUM_JOINTS-1:0] joint_feedback;
   logic [VIN_W-1:0]        process_variable;
   logic [BUFFER_SIZE-1:0]  tx_frame;
   logic [32*NUM_JOINTS-1:0] joint_freq_cmd;
   logic [NUM_JOINTS-1:0]   joint_enable;
   logic [VOUT_W-1:0]       set_point;
   logic [NUM_DOUT-1:0]     dout;
   logic                    error;
   logic [15:0]             frame_count;
`ifdef RIO_FRAME_CHECKSUM_EN
   logic                    csum_err;
`endif

   modport master (
      output rx_frame, rx_strobe, estop_in, din, joint_feedback, process_variable,
      input  tx_frame, joint_freq_cmd, joint_enable, set_point, dout, error, frame_count
`ifdef RIO_FRAME_CHECKSUM_EN
      , input csum_err
`endif
   );

   modport slave (
      input  rx_frame, rx_strobe, estop_in, din, joint_feedback, process_variable,
      output tx_frame, joint_freq_cmd, joint_enable, set_point, dout, error, frame_count
`ifdef RIO_FRAME_CHECKSUM_EN
      , output csum_err
`endif
   );
endinterface

// File: rtl/rio_frame_codec.sv
// rio_frame_codec: decodes SPI command frames into joint/vout/dout registers,
// snapshots feedback into the transmit frame, and runs the frame watchdog and
// ESTOP state machine that drive the TX header and the global error line.
// Words travel little-endian on the wire; the frame MSB is the first wire byte.
// Optional macro RIO_FRAME_CHECKSUM_EN: trailing XOR checksum byte on RX and TX,
// checked for validity, with csum_err pulsing on a header-good/checksum-bad frame.
module rio_frame_codec #(
   parameter int          NUM_JOINTS     = 5,
   parameter int          NUM_VOUTS      = 2,
   parameter int          NUM_VINS       = 1,
   parameter int          NUM_DOUT       = 4,
   parameter int          NUM_DIN        = 5,
   parameter logic [31:0] RX_HEADER      = 32'h74697277,
   parameter int          TIMEOUT_CYCLES = 100000
) (
   input logic              sysclk,
   input logic              rst,
   rio_frame_codec_if.slave bus
);
   // These must match the interface instance parameters.
   localparam int RX_BITS = 32*(1+NUM_JOINTS+NUM_VOUTS)+16;
   localparam int TX_BITS = 32*(1+NUM_JOINTS+NUM_VINS)+8;
`ifdef RIO_FRAME_CHECKSUM_EN
   localparam int BUFFER_SIZE = ((RX_BITS > TX_BITS) ? RX_BITS : TX_BITS) + 8;
`else
   localparam int BUFFER_SIZE = (RX_BITS > TX_BITS) ? RX_BITS : TX_BITS;
`endif
   localparam int VOUT_W   = (NUM_VOUTS > 0) ? 32*NUM_VOUTS : 32;
   localparam int VIN_W    = (NUM_VINS  > 0) ? 32*NUM_VINS  : 32;
   localparam int CMD_BASE = BUFFER_SIZE - 32*(1+NUM_JOINTS+NUM_VOUTS);
   localparam int TX_BASE  = BUFFER_SIZE - 32*(1+NUM_JOINTS+NUM_VINS);
   localparam int WD_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES-1);
   localparam logic [31:0] HDR_DATA = 32'h64617461;
   localparam logic [31:0] HDR_ESTP = 32'h65737470;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      RUN        = 2'd1,
      TIMEOUT    = 2'd2,
      ESTOP      = 2'd3
   } state_t;

   state_t state, state_next;

   // Converts between a value and its little-endian wire field (involution).
   function automatic logic [31:0] bswap(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   logic                      armed;
   logic                      hdr_ok, csum_ok, seen, valid, timeout, err;
   logic [WD_W-1:0]           wd_count;
   logic [32*NUM_JOINTS-1:0]  cmd_dec, cmd_q, fb_snap;
   logic [VOUT_W-1:0]         sp_dec, sp_q;
   logic [7:0]                en_byte, dout_byte;
   logic [NUM_JOINTS-1:0]     en_dec, en_q;
   logic [NUM_DOUT-1:0]       dout_dec, dout_q;
   logic [15:0]               fc_q;
   logic [VIN_W-1:0]          pv_snap;
   logic [NUM_DIN-1:0]        din_snap;
   logic [BUFFER_SIZE-1:0]    tx;
   logic                      unused_rx;

   // Pad bytes and spare enable/dout bits carry no meaning.
   assign unused_rx = ^bus.rx_frame;

   // Drops the first edge after reset release so a strobe held across reset is ignored.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) armed <= 1'b0;
      else     armed <= 1'b1;
   end

   // Unpacks the command fields of the received frame from their wire byte order.
   always_comb begin
      cmd_dec = '0;
      sp_dec  = '0;
      for (int j = 0; j < NUM_JOINTS; j++)
         cmd_dec[32*j +: 32] = bswap(bus.rx_frame[BUFFER_SIZE-32*(2+j) +: 32]);
      for (int v = 0; v < NUM_VOUTS; v++)
         sp_dec[32*v +: 32] = bswap(bus.rx_frame[BUFFER_SIZE-32*(2+NUM_JOINTS+v) +: 32]);
      en_byte   = bus.rx_frame[CMD_BASE-8 +: 8];
      dout_byte = bus.rx_frame[CMD_BASE-16 +: 8];
      en_dec    = en_byte[NUM_JOINTS-1:0];
      dout_dec  = dout_byte[NUM_DOUT-1:0];
   end

   assign hdr_ok = (bswap(bus.rx_frame[BUFFER_SIZE-32 +: 32]) == RX_HEADER);

`ifdef RIO_FRAME_CHECKSUM_EN
   logic [7:0] rx_sum;
   logic       csum_err_q;

   // XOR of every RX byte ahead of the checksum byte.
   always_comb begin
      rx_sum = '0;
      for (int b = 1; b < BUFFER_SIZE/8; b++)
         rx_sum = rx_sum ^ bus.rx_frame[8*b +: 8];
   end

   assign csum_ok = (rx_sum == bus.rx_frame[7:0]);

   // One-cycle flag for a frame whose header matched but whose checksum did not.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) csum_err_q <= 1'b0;
      else     csum_err_q <= seen & hdr_ok & ~csum_ok;
   end

   assign bus.csum_err = csum_err_q;
`else
   assign csum_ok = 1'b1;
`endif

   assign seen    = armed & bus.rx_strobe;
   assign valid   = seen & hdr_ok & csum_ok;
   assign timeout = (wd_count == WD_LAST);

   // State register.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) state <= WAIT_FIRST;
      else     state <= state_next;
   end

   // Next-state and error decode; ESTOP request beats any simultaneous frame.
   always_comb begin
      state_next = state;
      err        = 1'b1;
      case (state)
         WAIT_FIRST: if (valid) state_next = RUN;
         RUN: begin
            err = 1'b0;
            if (!valid && timeout) state_next = TIMEOUT;
         end
         TIMEOUT:    if (valid) state_next = RUN;
         ESTOP:      if (valid) state_next = RUN;
         default:    state_next = WAIT_FIRST;
      endcase
      if (bus.estop_in) state_next = ESTOP;
   end

   // Saturating frame watchdog, restarted by every valid frame and parked in ESTOP.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst)                          wd_count <= '0;
      else if (valid || state == ESTOP) wd_count <= '0;
      else if (!timeout)                wd_count <= wd_count + WD_W'(1);
   end

   // Command registers and frame counter, loaded only by a valid frame.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         cmd_q  <= '0;
         sp_q   <= '0;
         en_q   <= '0;
         dout_q <= '0;
         fc_q   <= '0;
      end else if (valid) begin
         cmd_q  <= cmd_dec;
         sp_q   <= sp_dec;
         en_q   <= en_dec;
         dout_q <= dout_dec;
         fc_q   <= fc_q + 16'd1;
      end
   end

   // Feedback snapshot taken together on any strobe so the next TX frame is coherent.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         fb_snap  <= '0;
         pv_snap  <= '0;
         din_snap <= '0;
      end else if (seen) begin
         fb_snap  <= bus.joint_feedback;
         pv_snap  <= bus.process_variable;
         din_snap <= bus.din;
      end
   end

   // Assembles the transmit frame; the header follows the current state every cycle.
   always_comb begin
      tx = '0;
      tx[BUFFER_SIZE-32 +: 32] = bswap((state == ESTOP) ? HDR_ESTP : HDR_DATA);
      for (int j = 0; j < NUM_JOINTS; j++)
         tx[BUFFER_SIZE-32*(2+j) +: 32] = bswap(fb_snap[32*j +: 32]);
      for (int i = 0; i < NUM_VINS; i++)
         tx[BUFFER_SIZE-32*(2+NUM_JOINTS+i) +: 32] = bswap(pv_snap[32*i +: 32]);
      tx[TX_BASE-8 +: 8] = 8'(din_snap);
`ifdef RIO_FRAME_CHECKSUM_EN
      for (int b = 1; b < BUFFER_SIZE/8; b++)
         tx[7:0] = tx[7:0] ^ tx[8*b +: 8];
`endif
   end

   assign bus.tx_frame       = tx;
   assign bus.joint_freq_cmd = cmd_q;
   assign bus.set_point      = sp_q;
   assign bus.dout           = dout_q;
   assign bus.error          = err;
   assign bus.joint_enable   = en_q & ~{NUM_JOINTS{err}};
   assign bus.frame_count    = fc_q;
endmodule

// File: tb/tb_rio_frame_codec.sv
// tb_rio_frame_codec: randomized and directed stimulus for rio_frame_codec,
// checked every cycle against a byte-stream reference model of the codec.
// Honours RIO_FRAME_CHECKSUM_EN when defined.
module tb_rio_frame_codec;
   localparam int NJ  = 5;
   localparam int NV  = 2;
   localparam int NI  = 1;
   localparam int NDO = 4;
   localparam int NDI = 5;
   localparam logic [31:0] HDR = 32'h74697277;
   localparam int TMO = 40;
   localparam int RXB = 32*(1+NJ+NV)+16;
   localparam int TXB = 32*(1+NJ+NI)+8;
`ifdef RIO_FRAME_CHECKSUM_EN
   localparam int BS = ((RXB > TXB) ? RXB : TXB) + 8;
`else
   localparam int BS = (RXB > TXB) ? RXB : TXB;
`endif
   localparam int NBYTES = BS/8;
   localparam int M_WAIT = 0, M_RUN = 1, M_TMO = 2, M_ESTOP = 3;

   logic sysclk = 1'b0;
   logic rst;

   always #5 sysclk = ~sysclk;

   rio_frame_codec_if #(.NUM_JOINTS(NJ), .NUM_VOUTS(NV), .NUM_VINS(NI),
                        .NUM_DOUT(NDO), .NUM_DIN(NDI)) bus ();

   rio_frame_codec #(.NUM_JOINTS(NJ), .NUM_VOUTS(NV), .NUM_VINS(NI), .NUM_DOUT(NDO),
                     .NUM_DIN(NDI), .RX_HEADER(HDR), .TIMEOUT_CYCLES(TMO))
      dut (.sysclk(sysclk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Frame contents to send and feedback values to drive.
   logic [31:0]    fHdr;
   logic [31:0]    fCmd [NJ];
   logic [31:0]    fSp  [NV];
   logic [7:0]     fEn, fDout;
   bit             fCorrupt;
   logic [31:0]    fb [NJ];
   logic [31:0]    pv [NI];
   logic [NDI-1:0] dinV;

   // Reference model state.
   logic [31:0] mCmd [NJ];
   logic [31:0] mSp  [NV];
   logic [7:0]  mEn, mDout, mDin;
   logic [15:0] mFc;
   logic [31:0] mFb [NJ];
   logic [31:0] mPv [NI];
   int          mMode, mIdle;
   bit          mArmed, mCsumErr;

   task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [BS-1:0] putByte(input logic [BS-1:0] v, input int k, input logic [7:0] b);
      logic [BS-1:0] r;
      r = v;
      r[BS-8-8*k +: 8] = b;
      return r;
   endfunction

   function automatic logic [BS-1:0] putWord(input logic [BS-1:0] v, input int w, input logic [31:0] d);
      logic [BS-1:0] r;
      r = v;
      for (int i = 0; i < 4; i++) r = putByte(r, 4*w+i, d[8*i +: 8]);
      return r;
   endfunction

   function automatic logic [BS-1:0] addChecksum(input logic [BS-1:0] v);
      logic [7:0] x;
      x = 8'h00;
      for (int k = 0; k < NBYTES-1; k++) x = x ^ v[BS-8-8*k +: 8];
      return putByte(v, NBYTES-1, x);
   endfunction

   function automatic logic [BS-1:0] buildRx();
      logic [BS-1:0] r;
      r = '0;
      r = putWord(r, 0, fHdr);
      for (int j = 0; j < NJ; j++) r = putWord(r, 1+j, fCmd[j]);
      for (int v = 0; v < NV; v++) r = putWord(r, 1+NJ+v, fSp[v]);
      r = putByte(r, 4*(1+NJ+NV), fEn);
      r = putByte(r, 4*(1+NJ+NV)+1, fDout);
`ifdef RIO_FRAME_CHECKSUM_EN
      r = addChecksum(r);
      if (fCorrupt) r[BS-8-8*5] = ~r[BS-8-8*5];
`endif
      return r;
   endfunction

   function automatic logic [BS-1:0] expTx();
      logic [BS-1:0] r;
      r = '0;
      r = putWord(r, 0, (mMode == M_ESTOP) ? 32'h65737470 : 32'h64617461);
      for (int j = 0; j < NJ; j++) r = putWord(r, 1+j, mFb[j]);
      for (int i = 0; i < NI; i++) r = putWord(r, 1+NJ+i, mPv[i]);
      r = putByte(r, 4*(1+NJ+NI), mDin);
`ifdef RIO_FRAME_CHECKSUM_EN
      r = addChecksum(r);
`endif
      return r;
   endfunction

   task automatic modelReset();
      for (int j = 0; j < NJ; j++) begin mCmd[j] = 0; mFb[j] = 0; end
      for (int v = 0; v < NV; v++) mSp[v] = 0;
      for (int i = 0; i < NI; i++) mPv[i] = 0;
      mEn = 0; mDout = 0; mDin = 0; mFc = 0;
      mMode = M_WAIT; mIdle = 0; mArmed = 0; mCsumErr = 0;
   endtask

   // Advances the model by one clock edge using the inputs that were presented.
   task automatic modelStep(input bit strobe, input bit est);
      bit seen, hdrGood, valid;
      int nextIdle;
      seen     = strobe && mArmed;
      hdrGood  = (fHdr == HDR);
      valid    = seen && hdrGood && !fCorrupt;
      mCsumErr = seen && hdrGood && fCorrupt;
      if (seen) begin
         for (int j = 0; j < NJ; j++) mFb[j] = fb[j];
         for (int i = 0; i < NI; i++) mPv[i] = pv[i];
         mDin = 8'(dinV);
      end
      if (valid) begin
         for (int j = 0; j < NJ; j++) mCmd[j] = fCmd[j];
         for (int v = 0; v < NV; v++) mSp[v] = fSp[v];
         mEn = fEn; mDout = fDout;
         mFc = mFc + 16'd1;
      end
      nextIdle = (valid || mMode == M_ESTOP) ? 0 : ((mIdle < TMO) ? mIdle + 1 : TMO);
      if (est) mMode = M_ESTOP;
      else if (mMode == M_RUN) begin
         if (!valid && nextIdle >= TMO) mMode = M_TMO;
      end else if (valid) mMode = M_RUN;
      mIdle  = nextIdle;
      mArmed = 1;
   endtask

   task automatic compareAll();
      logic [32*NJ-1:0] ec;
      logic [32*NV-1:0] es;
      logic [NJ-1:0]    ee;
      bit               err;
      err = (mMode != M_RUN);
      for (int j = 0; j < NJ; j++) ec[32*j +: 32] = mCmd[j];
      for (int v = 0; v < NV; v++) es[32*v +: 32] = mSp[v];
      ee = err ? '0 : mEn[NJ-1:0];
      checkOutput("error", 512'(bus.error), 512'(err));
      checkOutput("frame_count", 512'(bus.frame_count), 512'(mFc));
      checkOutput("joint_freq_cmd", 512'(bus.joint_freq_cmd), 512'(ec));
      checkOutput("joint_enable", 512'(bus.joint_enable), 512'(ee));
      checkOutput("set_point", 512'(bus.set_point), 512'(es));
      checkOutput("dout", 512'(bus.dout), 512'(mDout[NDO-1:0]));
      checkOutput("tx_frame", 512'(bus.tx_frame), 512'(expTx()));
`ifdef RIO_FRAME_CHECKSUM_EN
      checkOutput("csum_err", 512'(bus.csum_err), 512'(mCsumErr));
`endif
   endtask

   // Drives one cycle of inputs at the falling edge, then checks after the rising edge.
   task automatic applyStimulus(input bit strobe, input bit est, input bit doCheck);
      @(negedge sysclk);
      bus.rx_frame  = buildRx();
      bus.rx_strobe = strobe;
      bus.estop_in  = est;
      for (int j = 0; j < NJ; j++) bus.joint_feedback[32*j +: 32] = fb[j];
      for (int i = 0; i < NI; i++) bus.process_variable[32*i +: 32] = pv[i];
      bus.din = dinV;
      @(posedge sysclk);
      modelStep(strobe, est);
      #1;
      if (doCheck) compareAll();
   endtask

   task automatic clearFrame();
      fHdr = HDR; fEn = 0; fDout = 0; fCorrupt = 0;
      for (int j = 0; j < NJ; j++) fCmd[j] = 0;
      for (int v = 0; v < NV; v++) fSp[v] = 0;
   endtask

   initial begin
      #1_200_000;
      $display("[TB] FAIL sim_timeout: got no finish expected finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      bit est;
      rst = 1'b1;
      clearFrame();
      for (int j = 0; j < NJ; j++) fb[j] = 0;
      for (int i = 0; i < NI; i++) pv[i] = 0;
      dinV = '0;
      modelReset();
      // A valid frame strobe is held high across reset release.
      fCmd[0] = 32'h0BAD0BAD; fEn = 8'h1F;
      bus.rx_frame = buildRx(); bus.rx_strobe = 1'b1; bus.estop_in = 1'b0;
      bus.joint_feedback = '0; bus.process_variable = '0; bus.din = '0;
      repeat (2) @(posedge sysclk);
      #1;
      compareAll();
      #1 rst = 1'b0;
      applyStimulus(1, 0, 1);
      checkOutput("strobe_at_release_ignored", 512'(bus.frame_count), 512'(0));
      applyStimulus(0, 0, 1);

      // Wrong header leaves everything untouched.
      fHdr = 32'hDEADBEEF; fCmd[0] = 32'hAAAA5555; fDout = 8'h0F;
      applyStimulus(1, 0, 1);
      applyStimulus(0, 0, 1);
      checkOutput("bad_hdr_error", 512'(bus.error), 512'(1));
      checkOutput("bad_hdr_count", 512'(bus.frame_count), 512'(0));

      // First valid frame.
      clearFrame();
      fCmd[0] = 32'h00001234; fEn = 8'h01; fDout = 8'h05;
      applyStimulus(1, 0, 1);
      checkOutput("first_cmd0", 512'(bus.joint_freq_cmd[31:0]), 512'(32'h1234));
      checkOutput("first_en0", 512'(bus.joint_enable[0]), 512'(1));
      checkOutput("first_dout", 512'(bus.dout), 512'(4'h5));
      checkOutput("first_error", 512'(bus.error), 512'(0));
      checkOutput("first_count", 512'(bus.frame_count), 512'(1));

      // Watchdog expiry exactly TMO cycles after the frame.
      for (int k = 1; k <= TMO; k++) begin
         applyStimulus(0, 0, 1);
         if (k == TMO-1) checkOutput("tmo_before_edge", 512'(bus.error), 512'(0));
      end
      checkOutput("tmo_error", 512'(bus.error), 512'(1));
      checkOutput("tmo_enable", 512'(bus.joint_enable), 512'(0));
      applyStimulus(1, 0, 1);
      checkOutput("tmo_recover", 512'(bus.error), 512'(0));

      // ESTOP beats a simultaneous valid frame; exit needs release plus a frame.
      fEn = 8'h1F;
      applyStimulus(1, 1, 1);
      checkOutput("estop_hdr", 512'(bus.tx_frame[BS-32 +: 32]), 512'(32'h70747365));
      applyStimulus(0, 0, 1);
      checkOutput("estop_held", 512'(bus.error), 512'(1));
      applyStimulus(1, 0, 1);
      checkOutput("estop_exit_hdr", 512'(bus.tx_frame[BS-32 +: 32]), 512'(32'h61746164));
      checkOutput("estop_exit_err", 512'(bus.error), 512'(0));

      // Snapshot is taken at the strobe, later feedback changes stay out.
      fb[0] = 32'h11223344;
      applyStimulus(1, 0, 1);
      fb[0] = 32'h55667788;
      applyStimulus(0, 0, 1);
      checkOutput("snapshot_word", 512'(bus.tx_frame[BS-64 +: 32]), 512'(32'h44332211));

`ifdef RIO_FRAME_CHECKSUM_EN
      // Corrupted byte: pulse, commands held.
      fCmd[0] = 32'h77777777; fCorrupt = 1;
      applyStimulus(1, 0, 1);
      checkOutput("csum_pulse", 512'(bus.csum_err), 512'(1));
      checkOutput("csum_held", 512'(bus.joint_freq_cmd[31:0]), 512'(32'h1234));
      fCorrupt = 0;
      applyStimulus(0, 0, 1);
      checkOutput("csum_pulse_end", 512'(bus.csum_err), 512'(0));
`endif

      // Reset asserted mid-cycle clears state without waiting for an edge.
      fCmd[1] = 32'hCAFE0001; fEn = 8'h03; fDout = 8'h0A;
      applyStimulus(1, 0, 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_rst_count", 512'(bus.frame_count), 512'(0));
      checkOutput("async_rst_dout", 512'(bus.dout), 512'(0));
      checkOutput("async_rst_error", 512'(bus.error), 512'(1));
      modelReset();
      compareAll();
      @(posedge sysclk);
      #2 rst = 1'b0;
      applyStimulus(0, 0, 1);

      // Randomized traffic with busy and quiet phases.
      est = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit s;
         for (int j = 0; j < NJ; j++) begin fb[j] = $urandom; fCmd[j] = $urandom; end
         for (int i = 0; i < NI; i++) pv[i] = $urandom;
         for (int v = 0; v < NV; v++) fSp[v] = $urandom;
         dinV  = NDI'($urandom);
         fEn   = 8'($urandom);
         fDout = 8'($urandom);
         fHdr  = ($urandom_range(0, 4) == 0) ? 32'($urandom) : HDR;
`ifdef RIO_FRAME_CHECKSUM_EN
         fCorrupt = ($urandom_range(0, 7) == 0);
`endif
         s = ($urandom_range(0, 99) < ((((cyc/120) % 2) == 0) ? 35 : 3));
         if ($urandom_range(0, 99) < 4) est = !est;
         applyStimulus(s, est, 1);
      end

      // Frame counter wrap from a fresh reset.
      clearFrame();
      @(negedge sysclk);
      rst = 1'b1;
      bus.rx_strobe = 1'b0;
      bus.estop_in  = 1'b0;
      modelReset();
      @(posedge sysclk);
      #2 rst = 1'b0;
      applyStimulus(0, 0, 1);
      for (int n = 0; n < 65535; n++) applyStimulus(1, 0, 0);
      checkOutput("count_ffff", 512'(bus.frame_count), 512'(16'hFFFF));
      compareAll();
      applyStimulus(1, 0, 1);
      checkOutput("count_wrap", 512'(bus.frame_count), 512'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
